smart_mac_pe_gen2: RTL

Parametrised second-generation smart-bus processing element for the systolic MAC array. Each left/top operand can be sourced from the local neighbour or from the horizontal/vertical smart bus, and operands are forwarded right/bottom through registers. Unlike the first-generation element, it runs a length-configured, output-stationary accumulation under a small FSM. When the accumulation finishes, the element reports the full-precision result and can drive a saturated copy onto the smart buses for one cycle.

---
 rtl/smart_mac_pe_gen2.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/smart_mac_pe_gen2.sv
// smart_mac_pe_gen2: systolic MAC processing element with smart-bus operand
// sourcing, registered operand forwarding and a length-configured,
// output-stationary accumulation run by a three-state FSM
// (IDLE -> ACCUM -> DRAIN). When a run completes, the full-precision
// accumulator is reported and a saturated copy can be driven onto the
// smart buses for the single DRAIN cycle.
module smart_mac_pe_gen2 #(
    parameter int WORD_SIZE = 16,
    parameter int ACC_SIZE  = 32,   // must be >= 2*WORD_SIZE
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid_in,
    input  logic [CNT_WIDTH-1:0] cfg_len_in,
    input  logic                 valid_in,
    input  logic                 select_left_in_smart,
    input  logic                 select_top_in_smart,
    input  logic                 select_right_out_smart,
    input  logic                 select_bottom_out_smart,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    input  logic [WORD_SIZE-1:0] horizontal_smart_bus_in,
    input  logic [WORD_SIZE-1:0] vertical_smart_bus_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    output logic                 valid_out,
    output logic [WORD_SIZE-1:0] horizontal_smart_bus_out,
    output logic [WORD_SIZE-1:0] vertical_smart_bus_out,
    output logic [ACC_SIZE-1:0]  result_out,
    output logic                 result_valid_out,
    output logic                 busy_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Clamp bounds of a WORD_SIZE signed word, sign-extended to accumulator width.
    localparam logic signed [ACC_SIZE-1:0] SAT_MAX =
        {{(ACC_SIZE-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_SIZE-1:0] SAT_MIN =
        {{(ACC_SIZE-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_SIZE-1:0] mac_term_f(
        input logic signed [WORD_SIZE-1:0] x,
        input logic signed [WORD_SIZE-1:0] y
    );
        logic signed [2*WORD_SIZE-1:0] prod;
        prod       = x * y;
        mac_term_f = ACC_SIZE'(prod);
    endfunction

    // Saturate the accumulator into the smart-bus word range.
    function automatic logic signed [WORD_SIZE-1:0] sat_word_f(
        input logic signed [ACC_SIZE-1:0] v
    );
        if (v > SAT_MAX) begin
            sat_word_f = SAT_MAX[WORD_SIZE-1:0];
        end else if (v < SAT_MIN) begin
            sat_word_f = SAT_MIN[WORD_SIZE-1:0];
        end else begin
            sat_word_f = v[WORD_SIZE-1:0];
        end
    endfunction

    // ---- stage p0: operand selection and product (combinational) ----
    logic signed [WORD_SIZE-1:0] a_p0;
    logic signed [WORD_SIZE-1:0] b_p0;
    logic signed [ACC_SIZE-1:0]  term_p0;

    assign a_p0    = select_left_in_smart ? horizontal_smart_bus_in : left_in;
    assign b_p0    = select_top_in_smart  ? vertical_smart_bus_in   : top_in;
    assign term_p0 = mac_term_f(a_p0, b_p0);

    // ---- stage p1: registered state ----
    state_t                      state_p1;
    state_t                      state_nxt;
    logic signed [ACC_SIZE-1:0]  acc_p1;
    logic [CNT_WIDTH-1:0]        cnt_p1;
    logic signed [WORD_SIZE-1:0] right_p1;
    logic signed [WORD_SIZE-1:0] bottom_p1;
    logic                        vld_p1;

    logic                        load_en;
    logic                        acc_en;
    logic                        drain_act;
    logic signed [WORD_SIZE-1:0] sat_word;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    // Next-state and datapath enables; cfg is only honoured in IDLE and a
    // zero length is treated as no request.
    always_comb begin
        state_nxt = state_p1;
        load_en   = 1'b0;
        acc_en    = 1'b0;
        case (state_p1)
            IDLE: begin
                if (cfg_valid_in && (cfg_len_in != '0)) begin
                    load_en   = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (valid_in) begin
                    acc_en = 1'b1;
                    if (cnt_p1 == CNT_WIDTH'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator and remaining-pair counter; acc wraps modulo 2^ACC_SIZE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_p1 <= '0;
            cnt_p1 <= '0;
        end else if (load_en) begin
            acc_p1 <= '0;
            cnt_p1 <= cfg_len_in;
        end else if (acc_en) begin
            acc_p1 <= acc_p1 + term_p0;
            cnt_p1 <= cnt_p1 - CNT_WIDTH'(1);
        end
    end

    // Forward accepted operands to the right/bottom neighbours and echo valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            right_p1  <= '0;
            bottom_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= valid_in;
            if (valid_in) begin
                right_p1  <= a_p0;
                bottom_p1 <= b_p0;
            end
        end
    end

    // ---- output stage: status and smart-bus drive ----
    // Gating with rst keeps the buses pass-through and suppresses the result
    // pulse while reset is asserted, even if the FSM is currently in DRAIN.
    assign drain_act = rst && (state_p1 == DRAIN);
    assign sat_word  = sat_word_f(acc_p1);

    assign right_out        = right_p1;
    assign bottom_out       = bottom_p1;
    assign valid_out        = vld_p1;
    assign result_out       = acc_p1;
    assign result_valid_out = drain_act;
    assign busy_out         = (state_p1 != IDLE);

    assign horizontal_smart_bus_out = (drain_act && select_right_out_smart)
                                      ? sat_word : horizontal_smart_bus_in;
    assign vertical_smart_bus_out   = (drain_act && select_bottom_out_smart)
                                      ? sat_word : vertical_smart_bus_in;

endmodule
